// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared sizing and pointer helpers for the sync FIFO family
package sync_fifo_pkg;

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - DATA_WIDTH x DEPTH storage, synchronous write, asynchronous read
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - parametrised FWFT FIFO with level, watermarks and sticky errors
// Optional flush input enabled by defining SYNC_FIFO_FLUSH_EN.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
`ifdef SYNC_FIFO_FLUSH_EN
  input  logic                       flush,
`endif
  input  logic [DATA_WIDTH-1:0]      din,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clr_err,
  output logic [DATA_WIDTH-1:0]      dout,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          push_ok, pop_ok, flush_w;

`ifdef SYNC_FIFO_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign empty        = (level_q == '0);
  assign full         = (level_q == LW'(DEPTH));
  assign almost_full  = (level_q >= LW'(AF_LEVEL));
  assign almost_empty = (level_q <= LW'(AE_LEVEL));
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (flush_w) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (pop_ok)  rd_ptr_d = AW'(ptr_inc(int'(rd_ptr_q), DEPTH));
      if (push_ok) wr_ptr_d = AW'(ptr_inc(int'(wr_ptr_q), DEPTH));
      if (push_ok && !pop_ok)      level_d = level_q + LW'(1);
      else if (pop_ok && !push_ok) level_d = level_q - LW'(1);
      // A new error in the same cycle as clr_err keeps the flag set.
      if (clr_err) begin
        ovf_d = 1'b0;
        udf_d = 1'b0;
      end
      if (push && !push_ok) ovf_d = 1'b1;
      if (pop && !pop_ok)   udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok & ~flush_w & ~reset),
    .waddr (wr_ptr_q),
    .wdata (din),
    .raddr (rd_ptr_q),
    .rdata (dout)
  );

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - randomized and directed checks of sync_fifo_flags against a queue model
module tb_sync_fifo_flags;

  localparam int DW = 8;
  localparam int DEPTH = 5;
  localparam int AF = 4;
  localparam int AE = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] din = '0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] dout;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [2:0]    level;
`ifdef SYNC_FIFO_FLUSH_EN
  logic          flush = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mq[$];
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;

  sync_fifo_flags #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef SYNC_FIFO_FLUSH_EN
    .flush        (flush),
`endif
    .din          (din),
    .push         (push),
    .pop          (pop),
    .clr_err      (clr_err),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = mq.size();
    check("level", 32'(level), 32'(n));
    check("empty", 32'(empty), 32'(n == 0));
    check("full", 32'(full), 32'(n == DEPTH));
    check("almost_full", 32'(almost_full), 32'(n >= AF));
    check("almost_empty", 32'(almost_empty), 32'(n <= AE));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_udf));
    if (n > 0) check("dout", 32'(dout), 32'(mq[0]));
  endtask

  task automatic step(input logic p, input logic o, input logic [DW-1:0] d, input logic c);
    bit pop_ok, push_ok;
    @(negedge clk);
    push = p; pop = o; din = d; clr_err = c;
    @(posedge clk);
    pop_ok  = o && (mq.size() > 0);
    push_ok = p && (mq.size() < DEPTH || pop_ok);
    if (pop_ok) void'(mq.pop_front());
    if (push_ok) mq.push_back(d);
    if (c) begin m_ovf = 1'b0; m_udf = 1'b0; end
    if (p && !push_ok) m_ovf = 1'b1;
    if (o && !pop_ok) m_udf = 1'b1;
    #1;
    check_all();
  endtask

  task automatic do_reset(input logic p);
    @(negedge clk);
    reset = 1'b1; push = p; pop = 1'b0; din = 8'hEE; clr_err = 1'b0;
    @(posedge clk);
    mq.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0; push = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] last;
    int pr, qr;
    do_reset(1'b0);
    check("reset_level", 32'(level), 32'd0);

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h11 + i), 1'b0);
    check("fill_dout_head", 32'(dout), 32'h11);
    check("fill_full", 32'(full), 32'd1);

    step(1'b1, 1'b0, 8'hAA, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("drain_order", 32'(dout), 32'(8'h11 + i));
      step(1'b0, 1'b1, 8'h00, 1'b0);
    end
    check("drain_empty", 32'(empty), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 8'(i), 1'b0);
      check("wrap_dout", 32'(dout), 32'(i));
      step(1'b0, 1'b1, 8'h00, 1'b0);
    end

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
    step(1'b1, 1'b1, 8'h66, 1'b0);
    check("full_pp_level", 32'(level), 32'd5);
    check("full_pp_ovf", 32'(overflow), 32'd0);
    last = '0;
    for (int i = 0; i < 5; i++) begin
      last = dout;
      step(1'b0, 1'b1, 8'h00, 1'b0);
    end
    check("full_pp_last", 32'(last), 32'h66);

    step(1'b1, 1'b1, 8'h77, 1'b0);
    check("empty_pp_udf", 32'(underflow), 32'd1);
    check("empty_pp_dout", 32'(dout), 32'h77);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    check("clr_vs_set", 32'(underflow), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("clr_alone", 32'(underflow), 32'd0);

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h50 + i), 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    check("pre_reset_level", 32'(level), 32'd3);
    do_reset(1'b1);
    check("post_reset_ovf", 32'(overflow), 32'd0);

`ifdef SYNC_FIFO_FLUSH_EN
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    flush = 1'b1; push = 1'b1; pop = 1'b0;
    @(posedge clk);
    mq.delete();
    #1;
    check_all();
    check("flush_level", 32'(level), 32'd0);
    check("flush_keeps_ovf", 32'(overflow), 32'd1);
    @(negedge clk);
    flush = 1'b0; push = 1'b0;
    step(1'b0, 1'b0, 8'h00, 1'b1);
`endif

    for (int phase = 0; phase < 6; phase++) begin
      pr = (phase % 2 == 0) ? 80 : 25;
      qr = (phase % 2 == 0) ? 25 : 80;
      for (int i = 0; i < 60; i++) begin
        step(($urandom_range(99) < pr), ($urandom_range(99) < qr),
             8'($urandom), ($urandom_range(99) < 10));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
